// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the branch target buffer entry layout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default geometry of a 16-entry, 2-bit-counter predictor; instances re-derive the tag width.
  localparam int BTB_IDX_W    = 4;
  localparam int BTB_TAG_W    = 30 - BTB_IDX_W;
  localparam int BTB_CTR_BITS = 2;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_W-1:0]    tag;
    word_t                   target;
    logic [BTB_CTR_BITS-1:0] ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Combinational saturating up/down counter step used for branch direction training.
module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] next_ctr
);

  // Conflicting inc/dec requests leave the counter unchanged.
  always_comb begin
    next_ctr = ctr;
    if (inc && !dec && (ctr != {CTR_BITS{1'b1}})) begin
      next_ctr = ctr + CTR_BITS'(1);
    end else if (dec && !inc && (ctr != {CTR_BITS{1'b0}})) begin
      next_ctr = ctr - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Tagged, direct-mapped branch target buffer with saturating direction counters
// and branch/misprediction event counters.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic [31:0]                rd_pc,
  output logic                       pred_hit,
  output logic                       pred_taken,
  output logic [31:0]                pred_target,
  output logic [$clog2(ENTRIES)-1:0] pred_index,
  input  logic                       upd_en,
  input  logic [31:0]                upd_pc,
  input  logic                       upd_taken,
  input  logic [31:0]                upd_target,
  input  logic                       upd_mispredict,
  output logic [31:0]                br_count,
  output logic [31:0]                mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] WEAK_TAKEN     = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] WEAK_NOT_TAKEN = WEAK_TAKEN - CTR_BITS'(1);

  // Same layout as btb_entry_t, with the tag resized to this instance's index width.
  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    word_t               target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t              entries [ENTRIES];
  logic [31:0]         brCount;
  logic [31:0]         mispredictCount;

  logic [IDX_W-1:0]    rdIdx;
  logic [TAG_W-1:0]    rdTag;
  logic [IDX_W-1:0]    updIdx;
  logic [TAG_W-1:0]    updTag;
  logic                updHit;
  logic                updAccept;
  logic [CTR_BITS-1:0] nextCtr;
  logic                unusedPcBits;

  assign rdIdx  = rd_pc[IDX_W+1:2];
  assign rdTag  = rd_pc[31:IDX_W+2];
  assign updIdx = upd_pc[IDX_W+1:2];
  assign updTag = upd_pc[31:IDX_W+2];

  assign unusedPcBits = ^{rd_pc[1:0], upd_pc[1:0]};

  // Lookup reads the registered array directly, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit    = entries[rdIdx].valid && (entries[rdIdx].tag == rdTag);
    pred_taken  = pred_hit && entries[rdIdx].ctr[CTR_BITS-1];
    pred_target = pred_hit ? entries[rdIdx].target : 32'h0;
  end

  assign pred_index = rdIdx;

  assign updAccept = upd_en && !flush;
  assign updHit    = entries[updIdx].valid && (entries[updIdx].tag == updTag);

  sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) updCounter (
    .ctr      (entries[updIdx].ctr),
    .inc      (updHit && upd_taken),
    .dec      (updHit && !upd_taken),
    .next_ctr (nextCtr)
  );

  // Flush keeps tags and targets but forgets validity and direction history.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i].valid  <= 1'b0;
        entries[i].tag    <= '0;
        entries[i].target <= '0;
        entries[i].ctr    <= WEAK_NOT_TAKEN;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].ctr   <= WEAK_NOT_TAKEN;
      end
    end else if (updAccept) begin
      if (updHit) begin
        entries[updIdx].ctr <= nextCtr;
        if (upd_taken) begin
          entries[updIdx].target <= upd_target;
        end
      end else if (upd_taken) begin
        entries[updIdx].valid  <= 1'b1;
        entries[updIdx].tag    <= updTag;
        entries[updIdx].target <= upd_target;
        entries[updIdx].ctr    <= WEAK_TAKEN;
      end
    end
  end

  // Event counters survive flush and wrap naturally at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      brCount         <= 32'h0;
      mispredictCount <= 32'h0;
    end else if (updAccept) begin
      brCount <= brCount + 32'd1;
      if (upd_mispredict) begin
        mispredictCount <= mispredictCount + 32'd1;
      end
    end
  end

  assign br_count         = brCount;
  assign mispredict_count = mispredictCount;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: a 16x2-bit instance plus a 4x3-bit instance on shared stimulus.
module tb_branch_target_buffer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush;
  logic [31:0] rdPc;
  logic        updEn;
  logic [31:0] updPc;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updMispredict;

  logic        hitA, takenA;
  logic [31:0] targetA, brA, mispA;
  logic [3:0]  indexA;
  logic        hitB, takenB;
  logic [31:0] targetB, brB, mispB;
  logic [1:0]  indexB;

  int assertions = 0;
  int failures   = 0;

  always #5 CLK = ~CLK;

  branch_target_buffer #(.ENTRIES(16), .CTR_BITS(2)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .rd_pc(rdPc),
    .pred_hit(hitA), .pred_taken(takenA), .pred_target(targetA), .pred_index(indexA),
    .upd_en(updEn), .upd_pc(updPc), .upd_taken(updTaken), .upd_target(updTarget),
    .upd_mispredict(updMispredict), .br_count(brA), .mispredict_count(mispA)
  );

  branch_target_buffer #(.ENTRIES(4), .CTR_BITS(3)) dut4 (
    .CLK(CLK), .nRST(nRST), .flush(flush), .rd_pc(rdPc),
    .pred_hit(hitB), .pred_taken(takenB), .pred_target(targetB), .pred_index(indexB),
    .upd_en(updEn), .upd_pc(updPc), .upd_taken(updTaken), .upd_target(updTarget),
    .upd_mispredict(updMispredict), .br_count(brB), .mispredict_count(mispB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                               input logic mispredict);
    @(negedge CLK);
    updPc         = pc;
    updTaken      = taken;
    updTarget     = target;
    updMispredict = mispredict;
    updEn         = 1'b1;
    @(posedge CLK);
    #1 updEn = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    rdPc = pc;
    #1;
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; rdPc = 32'h40; updEn = 1'b0;
    updPc = 32'h0; updTaken = 1'b0; updTarget = 32'h0; updMispredict = 1'b0;
    #12;
    checkOutput("reset_hit", hitA, 0);
    checkOutput("reset_taken", takenA, 0);
    checkOutput("reset_target", targetA, 0);
    checkOutput("reset_br", brA, 0);
    checkOutput("reset_misp", mispA, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Allocation on a taken miss
    applyStimulus(32'h40, 1'b1, 32'h100, 1'b1);
    lookup(32'h40);
    checkOutput("alloc_hit", hitA, 1);
    checkOutput("alloc_taken", takenA, 1);
    checkOutput("alloc_target", targetA, 32'h100);
    checkOutput("alloc_index", indexA, 0);
    lookup(32'h440);
    checkOutput("alias_hit", hitA, 0);
    checkOutput("alias_target", targetA, 0);
    lookup(32'h44);
    checkOutput("index_44", indexA, 1);

    // Saturation at 3, then decay towards not-taken
    applyStimulus(32'h40, 1'b1, 32'h100, 1'b0);
    applyStimulus(32'h40, 1'b1, 32'h100, 1'b0);
    applyStimulus(32'h40, 1'b1, 32'h200, 1'b0);
    applyStimulus(32'h40, 1'b0, 32'h999, 1'b1);
    lookup(32'h40);
    checkOutput("sat_taken", takenA, 1);
    checkOutput("sat_target", targetA, 32'h200);
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0);
    lookup(32'h40);
    checkOutput("decay_hit", hitA, 1);
    checkOutput("decay_taken", takenA, 0);
    checkOutput("br_after7", brA, 7);
    checkOutput("misp_after7", mispA, 2);

    // Not-taken miss allocates nothing but still counts
    applyStimulus(32'h80, 1'b0, 32'h500, 1'b0);
    lookup(32'h80);
    checkOutput("nt_miss_hit", hitA, 0);
    checkOutput("nt_miss_br", brA, 8);

    // Flush wins over a simultaneous update
    @(negedge CLK);
    flush = 1'b1; updEn = 1'b1; updPc = 32'hC0; updTaken = 1'b1; updTarget = 32'h700; updMispredict = 1'b1;
    @(posedge CLK);
    #1 flush = 1'b0; updEn = 1'b0;
    lookup(32'h40);
    checkOutput("flush_hit40", hitA, 0);
    lookup(32'hC0);
    checkOutput("flush_hitC0", hitA, 0);
    checkOutput("flush_br", brA, 8);
    checkOutput("flush_misp", mispA, 2);

    // Same-cycle allocate and lookup returns the old contents
    @(negedge CLK);
    rdPc = 32'h40; updPc = 32'h40; updTaken = 1'b1; updTarget = 32'h300; updMispredict = 1'b0; updEn = 1'b1;
    #1 checkOutput("samecyc_hit", hitA, 0);
    @(posedge CLK);
    #1 updEn = 1'b0;
    checkOutput("nextcyc_hit", hitA, 1);
    checkOutput("nextcyc_taken", takenA, 1);
    checkOutput("nextcyc_target", targetA, 32'h300);

    // br_count wraps from all-ones
    @(negedge CLK);
    force dut.brCount = 32'hFFFF_FFFF;
    #1 release dut.brCount;
    #1 checkOutput("wrap_pre", brA, 32'hFFFF_FFFF);
    applyStimulus(32'h80, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_post", brA, 0);
    applyStimulus(32'h80, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_next", brA, 1);

    // Reset asserted while an update is pending
    @(negedge CLK);
    updPc = 32'h500; updTaken = 1'b1; updTarget = 32'h900; updEn = 1'b1;
    #2 nRST = 1'b0;
    @(posedge CLK);
    #1 updEn = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    lookup(32'h500);
    checkOutput("rstupd_hit", hitA, 0);
    checkOutput("rstupd_br", brA, 0);
    lookup(32'h40);
    checkOutput("rstupd_hit40", hitA, 0);

    // 4-entry, 3-bit instance: allocate weakly taken (4), floor at 0, climb back to 4
    applyStimulus(32'h40, 1'b1, 32'h80, 1'b0);
    lookup(32'h40);
    checkOutput("b_alloc_hit", hitB, 1);
    checkOutput("b_alloc_taken", takenB, 1);
    checkOutput("b_alloc_target", targetB, 32'h80);
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0);
    checkOutput("b_ctr3_taken", takenB, 0);
    for (int i = 0; i < 4; i++) applyStimulus(32'h40, 1'b0, 32'h0, 1'b0);
    checkOutput("b_floor_hit", hitB, 1);
    for (int i = 0; i < 3; i++) applyStimulus(32'h40, 1'b1, 32'h80, 1'b0);
    checkOutput("b_ctr3_again", takenB, 0);
    applyStimulus(32'h40, 1'b1, 32'h80, 1'b0);
    checkOutput("b_ctr4_taken", takenB, 1);
    lookup(32'h4C);
    checkOutput("b_index_4C", indexB, 3);
    lookup(32'h50);
    checkOutput("b_alias_hit", hitB, 0);
    checkOutput("b_br", brB, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised, tagged branch target buffer with per-entry saturating direction counters. It replaces the fixed 4-entry, untagged predictor in the fetch stage. Fetch looks it up combinationally with the current fetch address. The memory stage updates it once the branch resolves. It also keeps branch and misprediction event counters for performance measurement.

## Interface
Parameters:
- ENTRIES, 16: number of entries; power of two, ≥2. IDX_W = $clog2(ENTRIES).
- CTR_BITS, 2: width of the direction counter, ≥1.

Ports (word_t = 32 bits):
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous invalidate of all entries
- rd_pc  in  32  fetch address to look up
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predict taken (pred_hit & counter MSB)
- pred_target  out  32  stored target; 0 when !pred_hit
- pred_index  out  IDX_W  rd_pc[IDX_W+1:2]; carried down the pipe
- upd_en  in  1  a resolved beq/bne is in the memory stage this cycle
- upd_pc  in  32  address of the resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual branch target
- upd_mispredict  in  1  the pipeline flushed for this branch
- br_count  out  32  number of updates accepted
- mispredict_count  out  32  number of accepted updates with upd_mispredict

## Operation
- Entry fields: valid, tag = pc[31:IDX_W+2], target (32), ctr (CTR_BITS).
- Index = pc[IDX_W+1:2]. Lookup hits when valid and the tag matches rd_pc.
- Update, when upd_en and !flush, on entry e = upd_pc index:
  - Hit (valid and tag match):
    - upd_taken: ctr = min(ctr+1, 2^CTR_BITS−1); target = upd_target.
    - !upd_taken: ctr = max(ctr−1, 0); target unchanged.
  - Miss and upd_taken: allocate. valid=1, tag=upd_pc tag, target=upd_target, ctr = 2^(CTR_BITS−1) (weakly taken).
  - Miss and !upd_taken: no allocation; entry untouched.
- Event counters, each an unsigned 32-bit counter that wraps at 2^32−1 → 0:
  - br_count increments on every accepted update.
  - mispredict_count increments when an accepted update has upd_mispredict.
- flush: all valid bits clear and every ctr returns to 2^(CTR_BITS−1)−1 (weakly not-taken). The event counters are not cleared. flush has priority over an update in the same cycle; that update is dropped and not counted.

## Timing
- Lookup is purely combinational, with zero-cycle latency from rd_pc to the pred_* outputs.
- An update is written at the rising CLK edge and is visible to lookups from the next cycle.
- Same-cycle read and write of the same index: the lookup returns the pre-update contents. There is no bypass.
- Reset (nRST low, asynchronous):
  - all valid = 0, all ctr = 2^(CTR_BITS−1)−1, all tag and target fields = 0;
  - br_count = 0, mispredict_count = 0;
  - therefore pred_hit = 0, pred_taken = 0, pred_target = 0.
- Reset asserted during an update: reset wins and the update is lost.
- No state machine. Storage is an array of ENTRIES registers, plus two counter registers.

## Structure
- The btb_entry_t packed struct (valid, tag, target, ctr) lives in cpu_types_pkg. Its tag width is derived from a package-level localparam default, and the module overrides it with 30−IDX_W.
- The predictor-facing pipeline fields (btb_index, btb_taken, btb_target) stay in the pipeline_if stage structs. btb_index is widened to IDX_W.
- One sub-module: sat_counter. It is combinational, has parameter CTR_BITS, and maps inputs (ctr, inc, dec) to output next_ctr. The module instantiates it ENTRIES times, or once on the update path.

## Test plan
- Reset, ENTRIES=16, CTR_BITS=2: rd_pc=0x40 → pred_hit=0, pred_taken=0, pred_target=0; both event counters = 0.
- Allocate: update pc=0x40, taken, target=0x100. Next cycle rd_pc=0x40 → hit=1, taken=1, target=0x100. rd_pc=0x440 (same index, different tag) → hit=0.
- Saturation: 3 taken updates, then 1 not-taken, on pc=0x40 → still taken. 2 further not-taken → pred_taken=0 while pred_hit stays 1.
- Not-taken miss: update pc=0x80, !taken → pc 0x80 still misses. br_count increments by 1 anyway.
- Same-cycle update and lookup of pc=0x40 while allocating → pred_hit=0 that cycle and 1 the next. flush together with upd_en → update dropped, all entries miss, br_count unchanged.
- Counter wrap: force br_count to 0xFFFFFFFF, apply one update → br_count = 0. Repeat with ENTRIES=4, CTR_BITS=3: allocate sets ctr=4, and 4 not-taken updates give ctr=0.
